memory_dumper: RTL and testbench
================================

MEMORY_DUMPER -- requirements
Module: memory_dumper

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: memory address width in bits.
REQ-002 Parameter DATA_WIDTH, default 18: word width (9 trits, 2 bits per trit); SHALL be even.
REQ-003 clock  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clock.
REQ-005 start  input  1  begin a dump run; sampled only in IDLE.
REQ-006 base_addr  input  ADDR_WIDTH  first address to read; latched on accepted start.
REQ-007 word_count  input  ADDR_WIDTH+1  number of words to read; latched on accepted start.
REQ-008 mem_read  output  1  read strobe to program memory.
REQ-009 mem_addr  output  ADDR_WIDTH  read address; meaningful while mem_read=1.
REQ-010 mem_read_data  input  DATA_WIDTH  memory read data, valid the cycle after mem_read (synchronous read).
REQ-011 out_valid  output  1  out_data/out_addr hold a word for the consumer.
REQ-012 out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high at a posedge.
REQ-013 out_data  output  DATA_WIDTH  dumped word.
REQ-014 out_addr  output  ADDR_WIDTH  address the dumped word was read from.
REQ-015 busy  output  1  high in READ, WAIT and SEND.
REQ-016 done  output  1  one-cycle pulse at run end.
REQ-017 bad_trit  output  1  sticky: some word in the current run held an invalid trit code.

Function
REQ-018 States SHALL be IDLE, READ, WAIT, SEND, DONE.
REQ-019 IDLE: start=1 latches base_addr and word_count and clears bad_trit; count=0 -> DONE; otherwise -> READ.
REQ-020 start SHALL be ignored in every state other than IDLE.
REQ-021 READ: mem_read=1 and mem_addr=current address for exactly one cycle; -> WAIT.
REQ-022 WAIT: mem_read_data captured into out_data, current address into out_addr; -> SEND.
REQ-023 SEND: out_valid=1; out_data and out_addr SHALL hold stable until handshake.
REQ-024 On handshake: remaining count decrements and address increments modulo 2^ADDR_WIDTH; remaining was 1 -> DONE, else -> READ.
REQ-025 DONE: done=1 for exactly one cycle; -> IDLE.
REQ-026 Latency: start sampled at edge E -> mem_read high in cycle after E, out_valid high after edge E+2; with out_ready held high, one word every 3 cycles.
REQ-027 Trit encoding: 00=0, 01=+1, 10=-1, 11=invalid; any 11 pair in a captured word sets bad_trit, held until next accepted start or reset.
REQ-028 mem_read SHALL never be asserted outside READ; no speculative or extra reads under backpressure.
REQ-029 Outside SEND, out_valid=0; outside READ, mem_addr value is don't-care.

Reset
REQ-030 reset=1 at any posedge, including mid-run, SHALL force IDLE, discarding the run.
REQ-031 In the cycle after reset: mem_read, out_valid, busy, done, bad_trit = 0; out_data, out_addr, mem_addr = 0.
REQ-032 reset SHALL take priority over start and over a simultaneous handshake.

Verification
REQ-033 base=0x10, count=3, mem[10..12]=18'h00001,18'h00004,18'h00012, out_ready=1 -> words in order with out_addr 10,11,12; exactly 3 mem_read cycles; one done pulse; bad_trit=0.
REQ-034 out_ready=0 for 4 cycles during SEND of word 0 -> out_data/out_addr stable, no mem_read until handshake, then run completes normally.
REQ-035 count=0, start pulse -> no mem_read, no out_valid, done high in cycle after start sampled, busy never high.
REQ-036 ADDR_WIDTH=8, base=0xFF, count=2 -> mem_addr FF then 00, out_addr FF then 00.
REQ-037 word 18'h00003 read -> bad_trit=1 held through done; next start -> bad_trit=0.
REQ-038 reset during SEND -> out_valid=0, busy=0 next cycle, no done pulse; start during busy ignored (no restart, count unchanged).

Source files
------------

// File: rtl/memory_dumper.sv
// Streams a block of words out of a synchronous-read program memory to a ready/valid consumer,
// flagging any word that holds the invalid trit code 2'b11.
module memory_dumper #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 18
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  bad_trit
);

    localparam int unsigned NumTrits = DATA_WIDTH / 2;
    localparam logic [ADDR_WIDTH:0] RemOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StSend,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic                  bad_trit_q, bad_trit_d;
    logic                  word_bad;

    always_comb begin
        word_bad = 1'b0;
        for (int unsigned i = 0; i < NumTrits; i++) begin
            if (mem_read_data[2*i +: 2] == 2'b11) begin
                word_bad = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        out_addr_d  = out_addr_q;
        bad_trit_d  = bad_trit_q;
        mem_read    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = word_count;
                    bad_trit_d  = 1'b0;
                    state_d     = (word_count == '0) ? StDone : StRead;
                end
            end
            StRead: begin
                mem_read = 1'b1;
                busy     = 1'b1;
                state_d  = StWait;
            end
            StWait: begin
                busy       = 1'b1;
                data_d     = mem_read_data;
                out_addr_d = addr_q;
                if (word_bad) begin
                    bad_trit_d = 1'b1;
                end
                state_d = StSend;
            end
            StSend: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    remaining_d = remaining_q - RemOne;
                    addr_d      = addr_q + 1'b1;
                    state_d     = (remaining_q == RemOne) ? StDone : StRead;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            out_addr_q  <= '0;
            bad_trit_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
            out_addr_q  <= out_addr_d;
            bad_trit_q  <= bad_trit_d;
        end
    end

    // Address register doubles as the read address; it is only meaningful in READ.
    assign mem_addr = addr_q;
    assign out_data = data_q;
    assign out_addr = out_addr_q;
    assign bad_trit = bad_trit_q;

endmodule

// File: tb/tb_memory_dumper.sv
// Directed and randomized runs of memory_dumper against a synchronous memory model; expected
// words, addresses, read counts and bad-trit flags come from the memory array and address math.
module tb_memory_dumper;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [8:0]  word_count = '0;
    logic        mem_read;
    logic [7:0]  mem_addr;
    logic [17:0] mem_read_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [17:0] out_data;
    logic [7:0]  out_addr;
    logic        busy;
    logic        done;
    logic        bad_trit;

    logic [17:0] mem [256];
    int          rd_cnt = 0;
    int          errors = 0;
    int          checks = 0;

    memory_dumper #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(18)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .word_count   (word_count),
        .mem_read     (mem_read),
        .mem_addr     (mem_addr),
        .mem_read_data(mem_read_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_addr     (out_addr),
        .busy         (busy),
        .done         (done),
        .bad_trit     (bad_trit)
    );

    initial forever #5 clock = ~clock;

    // Synchronous-read memory; garbage on cycles with no read so late/early capture shows up.
    always @(posedge clock) begin
        if (mem_read) begin
            mem_read_data <= mem[mem_addr];
            rd_cnt        <= rd_cnt + 1;
        end else begin
            mem_read_data <= 18'($urandom);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic has_bad(input logic [17:0] w);
        for (int k = 0; k < 9; k++) begin
            if (((w >> (2 * k)) & 18'h3) == 18'h3) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic do_run(input int b, input int c, input int stall_word, input int stall_cycles);
        int   n;
        int   a;
        int   reads0;
        logic exp_bad;
        exp_bad = 1'b0;
        @(negedge clock);
        start      = 1'b1;
        base_addr  = 8'(b);
        word_count = 9'(c);
        reads0     = rd_cnt;
        @(negedge clock);
        start = 1'b0;
        check("bad_clr", bad_trit, 0);
        if (c == 0) begin
            check("zero_done", done, 1);
            check("zero_busy", busy, 0);
            check("zero_read", mem_read, 0);
            check("zero_valid", out_valid, 0);
        end else begin
            for (int i = 0; i < c; i++) begin
                a = (b + i) % 256;
                if (has_bad(mem[a])) exp_bad = 1'b1;
                check("rd_strobe", mem_read, 1);
                check("rd_addr", mem_addr, a);
                n = 0;
                do begin
                    @(negedge clock);
                    n++;
                end while (!out_valid && n < 10);
                check("valid_gap", n, 2);
                if (!out_valid) return;
                check("data", out_data, mem[a]);
                check("addr", out_addr, a);
                check("bad_run", bad_trit, exp_bad);
                if (i == stall_word) begin
                    out_ready = 1'b0;
                    repeat (stall_cycles) begin
                        @(negedge clock);
                        check("stall_valid", out_valid, 1);
                        check("stall_data", out_data, mem[a]);
                        check("stall_addr", out_addr, a);
                        check("stall_read", mem_read, 0);
                    end
                    out_ready = 1'b1;
                end
                @(negedge clock);
            end
            check("done", done, 1);
        end
        check("read_count", rd_cnt - reads0, c);
        @(negedge clock);
        check("done_end", done, 0);
        check("busy_end", busy, 0);
        check("bad_hold", bad_trit, exp_bad);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 18'($urandom);
        mem[8'h10] = 18'h00001;
        mem[8'h11] = 18'h00004;
        mem[8'h12] = 18'h00012;
        mem[8'h40] = 18'h00003;
        mem[8'h41] = 18'h00000;

        @(negedge clock);
        check("rst_read", mem_read, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bad", bad_trit, 0);
        check("rst_data", out_data, 0);
        check("rst_oaddr", out_addr, 0);
        check("rst_maddr", mem_addr, 0);
        reset = 1'b0;

        do_run(8'h10, 3, -1, 0);
        do_run(8'h10, 3, 0, 4);
        do_run(8'h33, 0, -1, 0);
        do_run(8'hFF, 2, -1, 0);
        do_run(8'h40, 2, -1, 0);
        do_run(8'h10, 1, -1, 0);

        // Stray start while busy, then reset during SEND with a simultaneous handshake.
        @(negedge clock);
        start      = 1'b1;
        base_addr  = 8'h20;
        word_count = 9'd5;
        @(negedge clock);
        base_addr  = 8'h80;
        word_count = 9'd1;
        @(negedge clock);
        @(negedge clock);
        start = 1'b0;
        check("busy_start_valid", out_valid, 1);
        check("busy_start_addr", out_addr, 8'h20);
        @(negedge clock);
        check("no_restart_read", mem_read, 1);
        check("no_restart_addr", mem_addr, 8'h21);
        @(negedge clock);
        @(negedge clock);
        check("w1_valid", out_valid, 1);
        check("w1_addr", out_addr, 8'h21);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_read", mem_read, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_oaddr", out_addr, 0);
        check("mid_rst_maddr", mem_addr, 0);
        @(negedge clock);
        check("post_rst_done", done, 0);
        check("post_rst_busy", busy, 0);

        for (int r = 0; r < 5; r++) begin
            do_run(int'($urandom_range(0, 255)), int'($urandom_range(1, 6)),
                   int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
